// File: rtl/count_chk_8b.sv
// count_chk_8b: sequence checker for the 8-bit free-running counter.
// Confirms that cnt_in advances by +1 mod 256 on every enabled cycle.
// An up_rst-forced 0 is accepted as a legal value. The block reports
// wrap-arounds (pulse + tally) and sequence losses (sticky flag,
// saturating count, lock indicator).
//
// Build option: define COUNT_CHK_RESYNC_EN to let LOST relock to TRACK
// after RESYNC consecutive good samples. When it is left undefined, LOST
// is absorbing until rst. In that case lock stays low after the first
// loss, and a loss is counted at most once per reset.
module count_chk_8b #(
    parameter int RESYNC = 4,
    parameter int WRAP_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [7:0]        cnt_in,
    input  logic              up_rst,
    input  logic              clr_err,
    output logic              lock,
    output logic              wrap,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err,
    output logic [7:0]        err_cnt
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_LOST  = 2'd2
    } state_t;

    // good_run is only 4 bits wide, so the relock threshold must fit in it.
    generate
        if (RESYNC < 2 || RESYNC > 15) begin : g_bad_resync
            $error("count_chk_8b: RESYNC must be in 2..15");
        end
    endgenerate

    state_t     state;
    logic [7:0] prev;
    logic [7:0] exp_val;
    logic       match;
    logic       wrap_hit;

`ifdef COUNT_CHK_RESYNC_EN
    localparam logic [3:0] RELOCK_AT = 4'(RESYNC - 1);
    logic [3:0] good_run;
`endif

    // While up_rst is high the counter is held at 0. Otherwise it must step by one.
    assign exp_val  = up_rst ? 8'd0 : prev + 8'd1;
    assign match    = (cnt_in == exp_val);
    // A genuine roll-over only. A forced 0 after 255 is not counted.
    assign wrap_hit = match && (prev == 8'hFF) && !up_rst;

    // Checker FSM, sample history and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_INIT;
            prev     <= 8'd0;
            lock     <= 1'b0;
            wrap     <= 1'b0;
            wrap_cnt <= '0;
            err      <= 1'b0;
            err_cnt  <= 8'd0;
`ifdef COUNT_CHK_RESYNC_EN
            good_run <= 4'd0;
`endif
        end else begin
            wrap <= 1'b0;

            // NOTE: the clear is scheduled first so that a loss on the same edge,
            // assigned further down, overrides it (the last non-blocking write wins).
            if (clr_err) begin
                err     <= 1'b0;
                err_cnt <= 8'd0;
            end

            if (en) begin
                prev <= cnt_in;

                case (state)
                    ST_INIT: begin
                        state <= ST_TRACK;
                        lock  <= 1'b1;
                    end

                    ST_TRACK: begin
                        if (match) begin
                            if (wrap_hit) begin
                                wrap     <= 1'b1;
                                wrap_cnt <= wrap_cnt + WRAP_W'(1);
                            end
                        end else begin
                            state   <= ST_LOST;
                            lock    <= 1'b0;
                            err     <= 1'b1;
                            err_cnt <= clr_err ? 8'd1 :
                                       (err_cnt == 8'hFF) ? 8'hFF : err_cnt + 8'd1;
`ifdef COUNT_CHK_RESYNC_EN
                            good_run <= 4'd0;
`endif
                        end
                    end

                    ST_LOST: begin
`ifdef COUNT_CHK_RESYNC_EN
                        if (match) begin
                            if (good_run == RELOCK_AT) begin
                                state    <= ST_TRACK;
                                lock     <= 1'b1;
                                good_run <= 4'd0;
                            end else begin
                                good_run <= good_run + 4'd1;
                            end
                        end else begin
                            good_run <= 4'd0;
                        end
`else
                        state <= ST_LOST;
`endif
                    end

                    default: begin
                        state <= ST_INIT;
                        lock  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_count_chk_8b.sv
// Directed testbench for count_chk_8b. The expected values are hand-derived.
// Some of them depend on whether COUNT_CHK_RESYNC_EN is defined for the build.
module tb_count_chk_8b;

    localparam int RESYNC = 4;
    localparam int WRAP_W = 16;

    logic              clk     = 1'b0;
    logic              rst     = 1'b0;
    logic              en      = 1'b0;
    logic [7:0]        cnt_in  = 8'd0;
    logic              up_rst  = 1'b0;
    logic              clr_err = 1'b0;
    logic              lock;
    logic              wrap;
    logic [WRAP_W-1:0] wrap_cnt;
    logic              err;
    logic [7:0]        err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    count_chk_8b #(
        .RESYNC (RESYNC),
        .WRAP_W (WRAP_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cnt_in   (cnt_in),
        .up_rst   (up_rst),
        .clr_err  (clr_err),
        .lock     (lock),
        .wrap     (wrap),
        .wrap_cnt (wrap_cnt),
        .err      (err),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Apply one sample, then wait for the edge. Outputs are read 1 ns after it.
    task automatic drive(input logic [7:0] c, input logic u, input logic e, input logic ce);
        cnt_in  = c;
        up_rst  = u;
        en      = e;
        clr_err = ce;
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [7:0] c);
        drive(c, 1'b0, 1'b1, 1'b0);
    endtask

    logic [7:0] c;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_lock", lock, 0);
        check("rst_wrap", wrap, 0);
        check("rst_wrap_cnt", wrap_cnt, 0);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        rst = 1'b1;

        // Free run 0..255, 0..19: lock from the first edge, one wrap at the second 0
        for (int i = 0; i < 276; i++) begin
            step(8'(i % 256));
            check("run_lock", lock, 1);
            check("run_wrap", wrap, (i == 256) ? 1 : 0);
        end
        check("run_wrap_cnt", wrap_cnt, 1);
        check("run_err", err, 0);

        // up_rst at count 100 restarts from 0: not an error and not a wrap
        for (int i = 20; i < 100; i++) step(8'(i));
        drive(8'd0, 1'b1, 1'b1, 1'b0);
        check("uprst_wrap", wrap, 0);
        check("uprst_err", err, 0);
        check("uprst_lock", lock, 1);
        for (int i = 1; i < 256; i++) step(8'(i));
        // up_rst-forced 0 right after 255 is still not a wrap
        drive(8'd0, 1'b1, 1'b1, 1'b0);
        check("uprst255_wrap", wrap, 0);
        check("uprst255_wrap_cnt", wrap_cnt, 1);
        check("uprst255_err", err, 0);
        check("uprst255_lock", lock, 1);
        for (int i = 1; i <= 5; i++) step(8'(i));

        // en=0 for 10 cycles while cnt_in wanders: everything frozen
        for (int i = 0; i < 10; i++) begin
            drive(8'(200 + i), 1'b0, 1'b0, 1'b0);
            check("hold_lock", lock, 1);
            check("hold_wrap", wrap, 0);
            check("hold_err", err, 0);
            check("hold_wrap_cnt", wrap_cnt, 1);
        end
        // next sample is compared with the held prev=5
        step(8'd6);
        check("resume_err", err, 0);
        check("resume_lock", lock, 1);

        // Skip 50 -> 52
        for (int i = 7; i <= 50; i++) step(8'(i));
        step(8'd52);
        check("skip_err", err, 1);
        check("skip_err_cnt", err_cnt, 1);
        check("skip_lock", lock, 0);
        step(8'd53);
        check("lost1_lock", lock, 0);
        step(8'd54);
        check("lost2_lock", lock, 0);
        step(8'd55);
        check("lost3_lock", lock, 0);
        step(8'd56);
`ifdef COUNT_CHK_RESYNC_EN
        check("relock_lock", lock, 1);
`else
        check("absorb_lock", lock, 0);
`endif
        check("relock_err_sticky", err, 1);
        // second skip: counted only if the checker relocked
        step(8'd58);
`ifdef COUNT_CHK_RESYNC_EN
        check("skip2_err_cnt", err_cnt, 2);
`else
        check("skip2_err_cnt", err_cnt, 1);
`endif
        check("skip2_lock", lock, 0);
        for (int i = 59; i <= 62; i++) step(8'(i));
`ifdef COUNT_CHK_RESYNC_EN
        check("relock2_lock", lock, 1);
        check("relock2_err_cnt", err_cnt, 2);
`else
        check("absorb2_lock", lock, 0);
        check("absorb2_err_cnt", err_cnt, 1);
`endif

        // Asynchronous reset mid-cycle, with no clock edge before the check
        #2;
        rst = 1'b0;
        #1;
        check("arst_lock", lock, 0);
        check("arst_wrap_cnt", wrap_cnt, 0);
        check("arst_err", err, 0);
        check("arst_err_cnt", err_cnt, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        // first enabled edge is INIT: any value is accepted
        step(8'd77);
        check("init_lock", lock, 1);
        check("init_err", err, 0);
        step(8'd78);
        step(8'd79);

        // clr_err on the same edge as a skip: the loss wins
        drive(8'd81, 1'b0, 1'b1, 1'b1);
        check("clrskip_err", err, 1);
        check("clrskip_err_cnt", err_cnt, 1);
`ifdef COUNT_CHK_RESYNC_EN
        for (int i = 82; i <= 85; i++) step(8'(i));
        step(8'd87);
        check("clrskip_pre_cnt", err_cnt, 2);
        for (int i = 88; i <= 91; i++) step(8'(i));
        drive(8'd93, 1'b0, 1'b1, 1'b1);
        check("clrskip2_err", err, 1);
        check("clrskip2_err_cnt", err_cnt, 1);
`endif
        // clr_err alone, and with en=0
        drive(8'd150, 1'b0, 1'b0, 1'b1);
        check("clr_err", err, 0);
        check("clr_err_cnt", err_cnt, 0);

`ifdef COUNT_CHK_RESYNC_EN
        // 300 isolated skips, each followed by a relock: err_cnt saturates
        c = 8'd93;
        for (int k = 0; k < RESYNC; k++) begin
            c = c + 8'd1;
            step(c);
        end
        check("sat_start_lock", lock, 1);
        for (int i = 0; i < 300; i++) begin
            c = c + 8'd2;
            step(c);
            if (i == 9) check("sat_cnt10", err_cnt, 10);
            if (i == 254) check("sat_cnt255", err_cnt, 255);
            for (int k = 0; k < RESYNC; k++) begin
                c = c + 8'd1;
                step(c);
            end
        end
        check("sat_final_cnt", err_cnt, 255);
        check("sat_final_err", err, 1);
        check("sat_final_lock", lock, 1);
`else
        // absorbing LOST: further skips never add to the cleared count
        step(8'd160);
        step(8'd170);
        check("absorb_clr_cnt", err_cnt, 0);
        check("absorb_clr_lock", lock, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/count_chk_8b.md
# count_chk_8b

Sequence checker that sits directly downstream of the 8-bit free-running counter. It consumes the counter's `out` value every enabled cycle and checks that it advances by exactly +1 modulo 256, with the counter's own reset tolerated. It reports wrap-arounds as a pulse plus a wrap tally, and reports sequence losses through a sticky flag, a saturating error count and a lock indicator. It is the self-check stage for the counter in simulation and on-board.

## Interface
- `RESYNC`, 4: consecutive in-sequence samples required to relock after a loss; legal range 2..15.
- `WRAP_W`, 16: width of the wrap tally.
- `clk` in 1: rising-edge clock, shared with the upstream counter.
- `rst` in 1: asynchronous, active-low reset (asserts when 0).
- `en` in 1: sample enable; when 0, all state holds.
- `cnt_in` in 8: counter value under check.
- `up_rst` in 1: upstream counter reset, active-high; when 1, `cnt_in` is expected to be 0.
- `clr_err` in 1: synchronous clear of `err` and `err_cnt`.
- `lock` out 1: 1 while state is TRACK.
- `wrap` out 1: one-cycle pulse on a 255→0 transition in TRACK.
- `wrap_cnt` out WRAP_W: number of wraps seen, modulo 2^WRAP_W.
- `err` out 1: sticky loss flag.
- `err_cnt` out 8: number of TRACK→LOST events, saturating at 255.

## Operation
- States: INIT, TRACK, LOST. Internal registers: `prev[7:0]` and `good_run[3:0]`.
- All action happens on the rising `clk` edge with `en`=1. `prev` loads `cnt_in` on every enabled edge in every state.
- Expected value: `exp` = 0 if `up_rst`=1, else `prev`+1 truncated to 8 bits. A sample matches when `cnt_in` == `exp`.
- INIT: no check; go to TRACK.
- TRACK, match: stay in TRACK.
  - If `prev`=255, `cnt_in`=0 and `up_rst`=0: pulse `wrap` and increment `wrap_cnt`.
  - An `up_rst`-forced 0 is not a wrap.
- TRACK, mismatch:
  - Go to LOST and set `err`=1.
  - `err_cnt` increments, saturating at 255.
  - `good_run` is cleared to 0.
- LOST, match: `good_run` increments. When it reaches RESYNC−1 on a match (the RESYNC-th consecutive good sample), go to TRACK and clear `good_run`.
- LOST, mismatch: clear `good_run`; `err_cnt` is unchanged.
- Wraps are not counted in INIT or LOST.
- `clr_err`=1 clears `err` and `err_cnt` regardless of `en`. If a new loss occurs on the same edge, the loss wins: `err`=1, `err_cnt`=1.
- `en`=0: state, `prev`, `good_run` and counters hold; `wrap`=0.

## Timing
- Reset values:
  - state INIT, `prev`=0, `good_run`=0.
  - `lock`=0, `wrap`=0, `wrap_cnt`=0, `err`=0, `err_cnt`=0.
- All outputs are registered. A result appears one edge after the sample: the edge that samples `cnt_in` updates the outputs, and they are visible until the next edge.
- `lock` rises on the first enabled edge after reset (INIT→TRACK).
- `wrap` is high for exactly one cycle per counted wrap.
- Loss to relock takes a minimum of RESYNC enabled edges.
- Reset asserted mid-operation forces reset values immediately, with no wait for `clk`. The first enabled edge after release is treated as INIT.
- `wrap_cnt` wraps silently from 2^WRAP_W−1 to 0.

## Configuration
- `COUNT_CHK_RESYNC_EN` defined: LOST relocks to TRACK after RESYNC matches, as described above.
- Not defined: LOST is absorbing. Only `rst` returns the block to INIT; `good_run` logic is removed and `lock` stays 0 after the first loss. `clr_err` still clears `err`/`err_cnt`, and a loss counts at most once per reset.

## Test plan
- Reset release, counter running 0..255..0..19 with `en`=1:
  - `lock`=1 from the first edge.
  - Exactly one `wrap` pulse, at the 255→0 sample.
  - Final `wrap_cnt`=1, `err`=0.
- `up_rst` pulsed for one cycle at count 100, then counting resumes from 0 → no error, no `wrap`, `lock` stays 1.
- Force `cnt_in` 50→52 once, then resume 53,54,…:
  - `err`=1, `err_cnt`=1, `lock`=0.
  - With the macro, `lock`=1 after 4 good samples.
  - Without the macro, `lock` stays 0.
- Inject 300 isolated skips, each followed by relock (macro on) → `err_cnt` saturates at 255.
- `clr_err` on the same edge as a skip → `err`=1, `err_cnt`=1. `clr_err` alone afterwards → `err`=0, `err_cnt`=0.
- Hold `en`=0 for 10 cycles while `cnt_in` keeps changing → all outputs frozen. On `en`=1 the next sample is checked against the held `prev`. Assert `rst` mid-run → all outputs return to reset values asynchronously.
